// File: rtl/bus_ram_if.sv
// Word-bus connection between the CPU (master) and the bus_ram memory target.
// Latency: none (wiring only).
// Backpressure: the master holds rd_en until it samples the one-cycle rd_valid pulse.
interface bus_ram_if;
  logic        rd_en;
  logic [15:0] addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        err;

  modport master (
    output rd_en,
    output addr,
    output wr_en,
    output wr_data,
    input  rd_data,
    input  rd_valid,
    input  err
  );

  modport slave (
    input  rd_en,
    input  addr,
    input  wr_en,
    input  wr_data,
    output rd_data,
    output rd_valid,
    output err
  );
endinterface

// File: rtl/bus_ram.sv
// Single-port word RAM target with programmable read wait states and sticky range error.
// Latency: rd_valid visible LATENCY cycles after the accept edge; writes take effect at their edge.
// Backpressure: reads are level requests; one pulse per request, rd_en must drop before a new read.
module bus_ram #(
  parameter int    DEPTH     = 4096,
  parameter int    LATENCY   = 1,
  parameter string INIT_FILE = ""
) (
  input  logic      clk,
  input  logic      rst,
  bus_ram_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [13:0] r_idx;
  logic [13:0] w_idx_nxt;
  logic [13:0] w_bus_idx;
  logic [13:0] w_rd_idx;
  logic        w_capture;
  logic        w_rd_inr;
  logic        w_wr_inr;
  logic        w_wr_do;
  logic        w_wr_oor;
  logic        w_unused_addr_lsbs;

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rd_data;
  logic        r_rd_valid;
  logic        r_err;

  // The array starts all-zero.
  initial begin
    for (int i = 0; i < DEPTH; i++) r_mem[i] = '0;
  end

  // Byte address to word index; the byte-lane bits carry no meaning on this bus.
  assign w_bus_idx          = bus.addr[15:2];
  assign w_unused_addr_lsbs = ^bus.addr[1:0];

  // Range checks are done on the full unsigned index so nothing wraps into the array.
  assign w_rd_inr = (int'(w_rd_idx) < DEPTH);
  assign w_wr_inr = (int'(w_bus_idx) < DEPTH);
  assign w_wr_do  = bus.wr_en && w_wr_inr && !rst;
  assign w_wr_oor = bus.wr_en && !w_wr_inr;

  // Next-state logic: accept in IDLE, count wait states, capture once, then hold until rd_en drops.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_capture   = 1'b0;
    w_rd_idx    = r_idx;
    case (r_state)
      S_IDLE: begin
        if (bus.rd_en) begin
          w_idx_nxt = w_bus_idx;
          w_rd_idx  = w_bus_idx;
          if (LATENCY == 1) begin
            w_capture   = 1'b1;
            w_state_nxt = S_HOLD;
          end else begin
            w_cnt_nxt   = 4'(LATENCY - 2);
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!bus.rd_en) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_HOLD: begin
        if (!bus.rd_en) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Control and read-data registers; an out-of-range capture returns zero and raises err.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_rd_valid <= w_capture;
      if (w_capture) begin
        r_rd_data <= w_rd_inr ? r_mem[w_rd_idx[AW-1:0]] : '0;
      end
      if ((w_capture && !w_rd_inr) || w_wr_oor) begin
        r_err <= 1'b1;
      end
    end
  end

  // Array write port; the read above sees the pre-write word when both hit the same edge.
  always_ff @(posedge clk) begin
    if (w_wr_do) begin
      r_mem[w_bus_idx[AW-1:0]] <= bus.wr_data;
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_bus_ram.sv
// Self-checking bench: four bus_ram instances (different DEPTH/LATENCY) share one stimulus stream.
// Expected results come from a shadow word array per instance and the rule "pulse LATENCY cycles after accept".
// Every wait is a fixed-length loop, so the run always ends at the summary line.
module tb_bus_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [15:0] addr;
  logic [31:0] wr_data;

  logic [3:0]  o_vld;
  logic [3:0]  o_err;
  logic [31:0] o_dat [4];

  int          n_checks;
  int          n_errors;

  logic [31:0] ref_mem [4][16384];
  logic [3:0]  exp_err;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 1;
      1:       return 4;
      2:       return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int dep_of(input int k);
    case (k)
      0:       return 64;
      2:       return 256;
      default: return 4096;
    endcase
  endfunction

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int GD = dep_of(g);
    localparam int GL = lat_of(g);
    bus_ram_if bi ();
    assign bi.rd_en   = rd_en;
    assign bi.addr    = addr;
    assign bi.wr_en   = wr_en;
    assign bi.wr_data = wr_data;
    assign o_vld[g]   = bi.rd_valid;
    assign o_err[g]   = bi.err;
    assign o_dat[g]   = bi.rd_data;
    bus_ram #(.DEPTH(GD), .LATENCY(GL)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bi)
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_write(input int idx, input logic [31:0] d);
    for (int k = 0; k < 4; k++) begin
      if (idx < dep_of(k)) ref_mem[k][idx] = d;
      else exp_err[k] = 1'b1;
    end
  endfunction

  task automatic do_write(input logic [15:0] a, input logic [31:0] d);
    int idx;
    idx = int'(a[15:2]);
    rd_en = 1'b0; wr_en = 1'b1; addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
    model_write(idx, d);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (o_err[k] !== exp_err[k]) begin
        n_errors++;
        $display("FAIL write_err dut%0d: got %b expected %b", k, o_err[k], exp_err[k]);
      end
    end
  endtask

  // Read held for 9 edges; optional same-address write at edge offset wofs from the accept edge.
  task automatic do_read(input logic [15:0] a, input int wofs, input logic [31:0] wdat);
    int          idx;
    logic [31:0] exp_d [4];
    logic        in_r;
    logic        exp_v;
    idx = int'(a[15:2]);
    for (int k = 0; k < 4; k++) begin
      in_r = (idx < dep_of(k));
      if (!in_r) exp_err[k] = 1'b1;
      if (wofs >= 0 && wofs < lat_of(k) - 1) exp_d[k] = in_r ? wdat : 32'h0;
      else exp_d[k] = in_r ? ref_mem[k][idx] : 32'h0;
    end
    if (wofs >= 0) model_write(idx, wdat);
    rd_en = 1'b1;
    for (int n = 0; n < 9; n++) begin
      if (n == wofs) begin
        wr_en = 1'b1; wr_data = wdat; addr = a;
      end else begin
        wr_en = 1'b0;
        addr  = (n == 0) ? a : 16'($urandom);
      end
      step();
      for (int k = 0; k < 4; k++) begin
        exp_v = (n == lat_of(k) - 1);
        n_checks++;
        if (o_vld[k] !== exp_v) begin
          n_errors++;
          $display("FAIL rd_valid dut%0d cyc%0d addr %h: got %b expected %b", k, n, a, o_vld[k], exp_v);
        end
        if (exp_v) begin
          n_checks++;
          if (o_dat[k] !== exp_d[k]) begin
            n_errors++;
            $display("FAIL rd_data dut%0d addr %h: got %h expected %h", k, a, o_dat[k], exp_d[k]);
          end
        end
      end
    end
    rd_en = 1'b0; wr_en = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (o_vld[k] !== 1'b0 || o_err[k] !== exp_err[k]) begin
        n_errors++;
        $display("FAIL read_end dut%0d: got vld %b err %b expected vld 0 err %b", k, o_vld[k], o_err[k], exp_err[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wr_data = '0;
    step();
    step();
    exp_err = '0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (o_vld[k] !== 1'b0 || o_dat[k] !== 32'h0 || o_err[k] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_state dut%0d: got vld %b dat %h err %b expected 0 0 0", k, o_vld[k], o_dat[k], o_err[k]);
      end
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_boot_vector();
    do_write(16'h0080, 32'h0000_0100);
    do_read(16'h0080, -1, 32'h0);
  endtask

  task automatic test_wait_states();
    do_write(16'h0044, 32'hDEAD_BEEF);
    do_read(16'h0047, -1, 32'h0);
  endtask

  // Registered master: sees the pulse one edge late, drops rd_en for one cycle, re-requests.
  task automatic test_back_to_back();
    logic [31:0] exp_w [2];
    logic        exp_v;
    do_write(16'h0004, $urandom);
    do_write(16'h0008, $urandom);
    exp_w[0] = ref_mem[0][1];
    exp_w[1] = ref_mem[0][2];
    for (int r = 0; r < 2; r++) begin
      rd_en = 1'b1;
      addr  = (r == 0) ? 16'h0004 : 16'h0008;
      for (int p = 0; p < 3; p++) begin
        if (p > 0) addr = 16'($urandom);
        if (p == 2) rd_en = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
          exp_v = (k == 0 && p == 0);
          n_checks++;
          if (o_vld[k] !== exp_v) begin
            n_errors++;
            $display("FAIL b2b_valid dut%0d req%0d ph%0d: got %b expected %b", k, r, p, o_vld[k], exp_v);
          end
        end
        if (p == 0) begin
          n_checks++;
          if (o_dat[0] !== exp_w[r]) begin
            n_errors++;
            $display("FAIL b2b_data req%0d: got %h expected %h", r, o_dat[0], exp_w[r]);
          end
        end
      end
    end
    for (int p = 0; p < 3; p++) begin
      step();
      n_checks++;
      if (o_vld !== 4'b0) begin
        n_errors++;
        $display("FAIL b2b_stale: got %b expected 0000", o_vld);
      end
    end
  endtask

  task automatic test_abort();
    logic [15:0] a;
    logic        exp_v;
    a = {14'($urandom_range(0, 63)), 2'b00};
    do_write(a, $urandom);
    rd_en = 1'b1; addr = a;
    for (int p = 0; p < 10; p++) begin
      if (p == 2) rd_en = 1'b0;
      step();
      for (int k = 0; k < 4; k++) begin
        exp_v = (k == 0 && p == 0);
        n_checks++;
        if (o_vld[k] !== exp_v) begin
          n_errors++;
          $display("FAIL abort_valid dut%0d cyc%0d: got %b expected %b", k, p, o_vld[k], exp_v);
        end
      end
    end
    do_read(a, -1, 32'h0);
  endtask

  task automatic test_out_of_range();
    do_write(16'h0100, 32'h1234_5678);
    do_read(16'h0100, -1, 32'h0);
    do_read(16'h0000, -1, 32'h0);
    rst = 1'b1;
    step();
    exp_err = '0;
    n_checks++;
    if (o_err !== 4'b0) begin
      n_errors++;
      $display("FAIL oor_err_clear: got %b expected 0000", o_err);
    end
    rst = 1'b0;
    step();
    do_read(16'h0080, -1, 32'h0);
  endtask

  task automatic test_reset_mid_read();
    logic [15:0] a;
    logic        exp_v;
    a = {14'($urandom_range(0, 63)), 2'b00};
    do_write(a, $urandom);
    rd_en = 1'b1; addr = a;
    for (int p = 0; p < 4; p++) begin
      step();
      for (int k = 0; k < 4; k++) begin
        exp_v = (p == lat_of(k) - 1);
        n_checks++;
        if (o_vld[k] !== exp_v) begin
          n_errors++;
          $display("FAIL pre_rst_valid dut%0d cyc%0d: got %b expected %b", k, p, o_vld[k], exp_v);
        end
      end
    end
    rst = 1'b1;
    step();
    exp_err = '0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (o_vld[k] !== 1'b0 || o_dat[k] !== 32'h0 || o_err[k] !== 1'b0) begin
        n_errors++;
        $display("FAIL mid_rst dut%0d: got vld %b dat %h err %b expected 0 0 0", k, o_vld[k], o_dat[k], o_err[k]);
      end
    end
    rst = 1'b0;
    do_read(a, -1, 32'h0);
  endtask

  task automatic test_random();
    int          idx;
    logic [15:0] a;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) idx = $urandom_range(64, 16383);
      else idx = $urandom_range(0, 79);
      a = {14'(idx), 2'($urandom)};
      if ($urandom_range(0, 2) == 0) do_write(a, $urandom);
      else if ($urandom_range(0, 1) == 0) do_read(a, int'($urandom_range(0, 8)), $urandom);
      else do_read(a, -1, 32'h0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_err  = '0;
    for (int k = 0; k < 4; k++)
      for (int w = 0; w < 16384; w++) ref_mem[k][w] = 32'h0;
    test_reset();
    test_boot_vector();
    test_wait_states();
    test_back_to_back();
    test_abort();
    test_out_of_range();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
